// File: rtl/solar_sample_scheduler_if.sv
// solar_sample_scheduler_if: core-side and pad-side signals of the solar
// sample scheduler. The scheduler connects through the slave modport; the
// core/ADC side (or a bench) connects through the master modport.
interface solar_sample_scheduler_if #(
  parameter int NCH = 4,
  parameter int DW  = 12
);
  localparam int CW = $clog2(NCH);

  logic           en_i;
  logic [DW-1:0]  thresh_i;
  logic           fault_clr_i;
  logic [DW-1:0]  sample_i;
  logic           sample_vld_i;
  logic           conv_start_o;
  logic           mux_en_o;
  logic [CW-1:0]  ch_sel_o;
  logic [DW-1:0]  avg_o;
  logic [CW-1:0]  avg_ch_o;
  logic           avg_vld_o;
  logic [NCH-1:0] low_flt_o;
  logic [NCH-1:0] to_flt_o;
  logic [2:0]     irq_o;
  logic           busy_o;

  modport master (
    output en_i, thresh_i, fault_clr_i, sample_i, sample_vld_i,
    input  conv_start_o, mux_en_o, ch_sel_o, avg_o, avg_ch_o, avg_vld_o,
    input  low_flt_o, to_flt_o, irq_o, busy_o
  );

  modport slave (
    input  en_i, thresh_i, fault_clr_i, sample_i, sample_vld_i,
    output conv_start_o, mux_en_o, ch_sel_o, avg_o, avg_ch_o, avg_vld_o,
    output low_flt_o, to_flt_o, irq_o, busy_o
  );
endinterface

// File: rtl/solar_sample_scheduler.sv
// solar_sample_scheduler: steps the analog mux through NCH sensor channels,
// waits for settling, triggers the ADC 2^AVG_LOG2 times per channel and
// reports the truncated average, with sticky low-output and ADC-timeout flags.
// Optional feature: define SOLAR_SCHED_TIMEOUT_EN to compile in the per
// conversion ADC watchdog; otherwise WAIT blocks indefinitely and the
// timeout flags / irq stay 0.
module solar_sample_scheduler #(
  parameter int NCH         = 4,
  parameter int DW          = 12,
  parameter int SETTLE_CYC  = 16,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                     wb_clk_i,
  input logic                     wb_rst_i,
  solar_sample_scheduler_if.slave bus
);
  localparam int CW  = $clog2(NCH);
  localparam int AW  = DW + AVG_LOG2;
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int NW  = AVG_LOG2 + 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  CH_LAST      = CW'(NCH - 1);
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYC - 1);
  localparam logic [NW-1:0]  SMP_LAST     = NW'((1 << AVG_LOG2) - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYC - 1);
`ifdef SOLAR_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CONV   = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t         state, state_nx, adv_state;
  logic [CW-1:0]  ch, ch_nx, ch_adv;
  logic [SCW-1:0] settle_cnt;
  logic [TCW-1:0] wait_cnt;
  logic [NW-1:0]  smp_cnt;
  logic [AW-1:0]  acc, sum;
  logic [DW-1:0]  avg_new;
  logic [NCH-1:0] ch_onehot;
  logic           last_smp, timeout, advance, report_ev, low_ev, sweep_end;

  // Datapath helpers: running sum, new average, event decodes and the
  // channel/state to move to once the current channel is finished.
  always_comb begin
    sum       = acc + {{AVG_LOG2{1'b0}}, bus.sample_i};
    avg_new   = sum[AW-1:AVG_LOG2];
    last_smp  = (smp_cnt == SMP_LAST);
    report_ev = (state == WAIT) && bus.sample_vld_i && last_smp;
    low_ev    = report_ev && (avg_new < bus.thresh_i);
    timeout   = TO_EN && (state == WAIT) && !bus.sample_vld_i &&
                (wait_cnt == TIMEOUT_LAST);
    advance   = (state == REPORT) || timeout;
    sweep_end = (report_ev || timeout) && (ch == CH_LAST);
    ch_onehot = '0;
    ch_onehot[ch] = 1'b1;
    if (ch == CH_LAST) begin
      ch_adv    = '0;
      adv_state = bus.en_i ? SETTLE : IDLE;
    end else begin
      ch_adv    = ch + CW'(1);
      adv_state = SETTLE;
    end
    ch_nx = advance ? ch_adv : ch;
  end

  // Next-state logic of the sequencing FSM.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.en_i) state_nx = SETTLE;
        else          state_nx = IDLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nx = CONV;
        else                           state_nx = SETTLE;
      end
      CONV:   state_nx = WAIT;
      WAIT: begin
        if (bus.sample_vld_i) state_nx = last_smp ? REPORT : CONV;
        else if (timeout)     state_nx = adv_state;
        else                  state_nx = WAIT;
      end
      REPORT: state_nx = adv_state;
      default: state_nx = IDLE;
    endcase
  end

  // State and current-channel registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
    end
  end

  // Settle timer, ADC watchdog counter and sample accumulator.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      settle_cnt <= '0;
      wait_cnt   <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + SCW'(1) : '0;
      wait_cnt   <= (TO_EN && state == WAIT) ? wait_cnt + TCW'(1) : '0;
      if (state_nx == SETTLE) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else if (state == WAIT && bus.sample_vld_i) begin
        acc     <= sum;
        smp_cnt <= smp_cnt + NW'(1);
      end
    end
  end

  // Registered outputs decoded from the next state; a flag set beats a
  // same-cycle clear for that bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus.conv_start_o <= 1'b0;
      bus.mux_en_o     <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.ch_sel_o     <= '0;
      bus.avg_o        <= '0;
      bus.avg_ch_o     <= '0;
      bus.avg_vld_o    <= 1'b0;
      bus.irq_o        <= 3'b000;
      bus.low_flt_o    <= '0;
      bus.to_flt_o     <= '0;
    end else begin
      bus.conv_start_o <= (state_nx == CONV);
      bus.mux_en_o     <= (state_nx != IDLE);
      bus.busy_o       <= (state_nx != IDLE);
      bus.ch_sel_o     <= ch_nx;
      bus.avg_vld_o    <= report_ev;
      if (report_ev) begin
        bus.avg_o    <= avg_new;
        bus.avg_ch_o <= ch;
      end
      bus.irq_o     <= {sweep_end, timeout, low_ev};
      bus.low_flt_o <= (bus.low_flt_o & ~{NCH{bus.fault_clr_i}}) |
                       (low_ev ? ch_onehot : '0);
      bus.to_flt_o  <= (bus.to_flt_o & ~{NCH{bus.fault_clr_i}}) |
                       (timeout ? ch_onehot : '0);
    end
  end
endmodule

// File: tb/tb_solar_sample_scheduler.sv
// tb_solar_sample_scheduler: randomized/directed sweeps against a reference
// model of per-channel averages; expectations are queued at stimulus time and
// popped by a monitor whenever the scheduler reports. Timeout scenario runs
// only when SOLAR_SCHED_TIMEOUT_EN is defined.
module tb_solar_sample_scheduler;
  localparam int NCH = 4, DW = 12, SETTLE_CYC = 16, AVG_LOG2 = 2, TIMEOUT_CYC = 255;
  localparam int NS = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  solar_sample_scheduler_if #(.NCH(NCH), .DW(DW)) bus();

  solar_sample_scheduler #(
    .NCH(NCH), .DW(DW), .SETTLE_CYC(SETTLE_CYC),
    .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );

  typedef struct { int ch; int avg; bit low; bit to; bit clr; } exp_t;
  exp_t exp_q[$];
  int   adc_q[NCH][$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   last_vld_cyc = -100;
  int   drop_ch = -1;
  bit   clr_arm = 1'b0;
  logic [NCH-1:0] m_low = '0, m_to = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: average is the integer mean of the channel's samples.
  task automatic push_ch(input int ch, input int s0, input int s1, input int s2,
                         input int s3, input bit clr);
    exp_t e;
    adc_q[ch].push_back(s0); adc_q[ch].push_back(s1);
    adc_q[ch].push_back(s2); adc_q[ch].push_back(s3);
    e.ch = ch; e.avg = (s0 + s1 + s2 + s3) / NS;
    e.low = (e.avg < int'(bus.thresh_i)); e.to = 1'b0; e.clr = clr;
    exp_q.push_back(e);
  endtask

  task automatic push_rand(input int ch);
    push_ch(ch, $urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0);
  endtask

  task automatic push_to(input int ch);
    exp_t e;
    e.ch = ch; e.avg = 0; e.low = 1'b0; e.to = 1'b1; e.clr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("sweep_done_in_budget", int'(n < budget), 1);
  endtask

  task automatic start_sweep();
    int n = 0;
    bus.en_i = 1'b1;
    @(negedge clk);
    while (!bus.busy_o && n < 10) begin @(negedge clk); n++; end
    chk("idle_to_settle_latency", n, 0);
  endtask

  task automatic run_one();
    start_sweep();
    bus.en_i = 1'b0;
    wait_done(3000);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_conv_start"}, int'(bus.conv_start_o), 0);
    chk({tag, "_mux_en"},     int'(bus.mux_en_o), 0);
    chk({tag, "_ch_sel"},     int'(bus.ch_sel_o), 0);
    chk({tag, "_avg"},        int'(bus.avg_o), 0);
    chk({tag, "_avg_ch"},     int'(bus.avg_ch_o), 0);
    chk({tag, "_avg_vld"},    int'(bus.avg_vld_o), 0);
    chk({tag, "_low_flt"},    int'(bus.low_flt_o), 0);
    chk({tag, "_to_flt"},     int'(bus.to_flt_o), 0);
    chk({tag, "_irq"},        int'(bus.irq_o), 0);
    chk({tag, "_busy"},       int'(bus.busy_o), 0);
  endtask

  // ADC model: answers each conv_start after 1..4 cycles with the next queued
  // sample of the selected channel; optionally fires fault_clr with the last
  // sample of channel 0.
  initial begin : adc
    int ch, d;
    bus.sample_vld_i = 1'b0; bus.sample_i = '0; bus.fault_clr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.conv_start_o && int'(bus.ch_sel_o) != drop_ch) begin
        ch = int'(bus.ch_sel_o);
        d  = $urandom_range(1, 4);
        repeat (d) @(posedge clk);
        #1;
        if (adc_q[ch].size() > 0) bus.sample_i = DW'(adc_q[ch].pop_front());
        else bus.sample_i = '0;
        bus.fault_clr_i = clr_arm && ch == 0 && adc_q[0].size() == 0;
        if (bus.fault_clr_i) clr_arm = 1'b0;
        bus.sample_vld_i = 1'b1;
        last_vld_cyc = cyc;
        @(posedge clk); #1;
        bus.sample_vld_i = 1'b0; bus.fault_clr_i = 1'b0;
      end
    end
  end

  // Monitor: timing of conv_start, and every report/timeout against the queue.
  initial begin : monitor
    bit   prev_mux, settle_pend;
    int   prev_ch, entry_cyc, conv_cyc;
    exp_t e;
    prev_mux = 1'b0; settle_pend = 1'b0; prev_ch = 0; entry_cyc = 0; conv_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mux = 1'b0; settle_pend = 1'b0;
      end else begin
        if (bus.mux_en_o && (!prev_mux || int'(bus.ch_sel_o) != prev_ch)) begin
          entry_cyc = cyc; settle_pend = 1'b1;
        end
        prev_mux = bus.mux_en_o; prev_ch = int'(bus.ch_sel_o);
        if (bus.conv_start_o) begin
          if (settle_pend) chk("settle_to_conv", cyc - entry_cyc, SETTLE_CYC);
          else             chk("vld_to_conv", cyc - last_vld_cyc, 1);
          settle_pend = 1'b0; conv_cyc = cyc;
        end
        if (bus.avg_vld_o || bus.irq_o[1]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_report", 1, 0);
          end else begin
            e = exp_q.pop_front();
            if (e.clr) begin m_low = '0; m_to = '0; end
            if (e.low) m_low[e.ch] = 1'b1;
            if (e.to)  m_to[e.ch]  = 1'b1;
            chk("timeout_pulse", int'(bus.irq_o[1]), int'(e.to));
            chk("avg_vld", int'(bus.avg_vld_o), int'(!e.to));
            if (!e.to) begin
              chk("avg_value", int'(bus.avg_o), e.avg);
              chk("avg_channel", int'(bus.avg_ch_o), e.ch);
              chk("low_irq", int'(bus.irq_o[0]), int'(e.low));
              chk("vld_to_avg", cyc - last_vld_cyc, 1);
            end else begin
              chk("timeout_latency", cyc - conv_cyc, TIMEOUT_CYC + 1);
              chk("ch_after_timeout", int'(bus.ch_sel_o), (e.ch + 1) % NCH);
            end
            chk("sweep_done_irq", int'(bus.irq_o[2]), int'(e.ch == NCH - 1));
            chk("low_flt", int'(bus.low_flt_o), int'(m_low));
            chk("to_flt", int'(bus.to_flt_o), int'(m_to));
          end
        end else if (bus.irq_o != 3'b000) begin
          chk("stray_irq", int'(bus.irq_o), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bus.en_i = 1'b0; bus.thresh_i = 12'd100;
    #1;
    check_reset("init");
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Normal sweep: every channel 200..203 -> 201, no low faults.
    for (int c = 0; c < NCH; c++) push_ch(c, 200, 201, 202, 203, 1'b0);
    run_one();

    // Low fault on channel 2.
    for (int c = 0; c < NCH; c++)
      if (c == 2) push_ch(c, 50, 50, 51, 51, 1'b0);
      else        push_ch(c, 200, 201, 202, 203, 1'b0);
    run_one();

    // Clear in the same cycle channel 0 sets its low flag.
    clr_arm = 1'b1;
    push_ch(0, 10, 20, 30, 40, 1'b1);
    for (int c = 1; c < NCH; c++) push_ch(c, 200, 201, 202, 203, 1'b0);
    run_one();

    // Back-to-back sweeps, enable dropped during channel 1 of the second.
    bus.thresh_i = DW'($urandom_range(0, 4095));
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NCH; c++) push_rand(c);
    start_sweep();
    n = 0;
    while (exp_q.size() > 3 && n < 3000) begin @(negedge clk); n++; end
    chk("reached_second_sweep_ch1", int'(n < 3000), 1);
    bus.en_i = 1'b0;
    wait_done(3000);
    chk("idle_busy", int'(bus.busy_o), 0);
    chk("idle_mux_en", int'(bus.mux_en_o), 0);

    // Randomized sweeps with random thresholds.
    for (int r = 0; r < 5; r++) begin
      bus.thresh_i = DW'($urandom_range(0, 4095));
      for (int c = 0; c < NCH; c++) push_rand(c);
      run_one();
    end

`ifdef SOLAR_SCHED_TIMEOUT_EN
    // ADC silent on channel 1.
    drop_ch = 1;
    for (int c = 0; c < NCH; c++)
      if (c == 1) push_to(c);
      else        push_rand(c);
    run_one();
    drop_ch = -1;
`endif

    // Reset asserted while waiting for an ADC answer.
    for (int k = 0; k < NS; k++) adc_q[0].push_back(500);
    start_sweep();
    bus.en_i = 1'b0;
    n = 0;
    while (!bus.conv_start_o && n < 40) begin @(negedge clk); n++; end
    chk("conv_before_reset", int'(bus.conv_start_o), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset("mid_wait");
    repeat (8) @(negedge clk);
    for (int c = 0; c < NCH; c++) adc_q[c].delete();
    m_low = '0; m_to = '0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", int'(bus.busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/solar_sample_scheduler.md
# solar_sample_scheduler

Sequencing controller for the solar-monitor sensor front end. It steps an external analog mux through the panel sensor channels, waits for the mux to settle, triggers the external ADC and collects 2^AVG_LOG2 samples per channel. It reports a truncated average per channel and flags channels whose average falls below a threshold or whose ADC fails to answer. It sits between the Wishbone-clocked core logic and the io_in/io_out pads, and drives the user IRQ lines.

## Interface
- NCH, 4: number of sensor channels (2..8).
- DW, 12: ADC sample width.
- SETTLE_CYC, 16: mux settle cycles per channel (≥1).
- AVG_LOG2, 2: log2 of samples averaged per channel.
- TIMEOUT_CYC, 255: maximum wait for sample_vld_i per conversion.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  run sweeps while high.
- thresh_i  in  DW  low-output threshold, unsigned.
- fault_clr_i  in  1  one-cycle pulse that clears all sticky fault bits.
- sample_i  in  DW  ADC result, qualified by sample_vld_i.
- sample_vld_i  in  1  ADC result valid (single-cycle).
- conv_start_o  out  1  one-cycle ADC start pulse.
- mux_en_o  out  1  analog mux enable.
- ch_sel_o  out  clog2(NCH)  mux channel select.
- avg_o  out  DW  last channel average.
- avg_ch_o  out  clog2(NCH)  channel of avg_o.
- avg_vld_o  out  1  one-cycle strobe, avg_o/avg_ch_o new.
- low_flt_o  out  NCH  sticky below-threshold flags.
- to_flt_o  out  NCH  sticky ADC-timeout flags.
- irq_o  out  3  [0] low fault set, [1] timeout, [2] sweep done; all one-cycle pulses.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETTLE, CONV, WAIT, REPORT.
- IDLE: mux_en_o=0. When en_i=1, load channel 0, go to SETTLE.
- SETTLE:
  - mux_en_o=1, ch_sel_o=current channel.
  - Count SETTLE_CYC cycles, then go to CONV.
  - Clear the accumulator and the sample count on entry.
- CONV: conv_start_o=1 for this single cycle, then go to WAIT.
- WAIT:
  - On sample_vld_i: add sample_i into a DW+AVG_LOG2-bit accumulator; this cannot overflow.
  - If sample count < 2^AVG_LOG2 after the add, return to CONV. There is no re-settle. Otherwise go to REPORT.
  - sample_vld_i in any other state is ignored.
- REPORT:
  - avg_o = acc >> AVG_LOG2 (truncation); avg_ch_o = channel; avg_vld_o=1.
  - If avg_o < thresh_i (unsigned compare of the new value), set low_flt_o[ch] and pulse irq_o[0]. irq_o[0] pulses even if the bit was already set.
- Channel advance after REPORT or a timeout:
  - If channel < NCH-1: increment and go to SETTLE.
  - At NCH-1: pulse irq_o[2] and wrap to 0. Then go to SETTLE if en_i=1, else IDLE.
- en_i is sampled only in IDLE and at sweep end. Deasserting en_i mid-sweep lets the sweep finish.
- fault_clr_i clears both flag vectors. If a set and a clear land in the same cycle, the set wins for that bit.
- Reset mid-operation returns the FSM to IDLE immediately. Any partial accumulation is discarded.

## Timing
- Reset values:
  - All outputs 0, ch_sel_o=0, avg_o=0.
  - FSM in IDLE.
  - All counters 0.
- Outputs are registered. Strobes are high exactly one cycle.
- Entry into SETTLE is 1 cycle after en_i is seen high in IDLE.
- conv_start_o rises SETTLE_CYC cycles after SETTLE entry.
- sample_vld_i may arrive 1 cycle after conv_start_o at the earliest. The next conv_start_o is then 1 cycle after that sample_vld_i.
- avg_vld_o is 1 cycle after the last sample_vld_i of the channel.
- irq_o[2] is coincident with the last channel's avg_vld_o, or with its timeout pulse.
- ch_sel_o changes in the cycle the FSM enters SETTLE. It is stable through SETTLE, CONV and WAIT.

## Configuration
- SOLAR_SCHED_TIMEOUT_EN defined (timeout watchdog compiled in):
  - WAIT counts cycles from CONV exit.
  - If TIMEOUT_CYC cycles pass with no sample_vld_i: set to_flt_o[ch], pulse irq_o[1], skip REPORT for that channel (no avg_vld_o), advance channel.
- Undefined: WAIT waits indefinitely; to_flt_o and irq_o[1] are tied 0.

## Test plan
- Reset: assert wb_rst_i mid-WAIT → all outputs 0 next edge, busy_o=0, ch_sel_o=0.
- Normal sweep: NCH=4, AVG_LOG2=2, thresh_i=100; samples 200,201,202,203 on every channel → four avg_vld_o with avg_o=201 and avg_ch_o 0..3; irq_o[2] with the 4th; low_flt_o=0.
- Low fault: channel 2 samples 50,50,51,51, thresh_i=100 → avg_o=50, low_flt_o=4'b0100, irq_o[0] pulse coincident with avg_vld_o.
- Timeout (macro defined): no sample_vld_i on channel 1 → irq_o[1] pulse after 255 WAIT cycles, to_flt_o=4'b0010, no avg_vld_o for ch1, ch_sel_o→2.
- Clear vs set: fault_clr_i pulsed in the same cycle channel 0 sets low_flt_o[0] → low_flt_o[0]=1; every other bit cleared.
- Enable drop: en_i=0 during channel 1 → sweep completes through channel 3, irq_o[2] pulses, FSM returns to IDLE, busy_o=0, mux_en_o=0.
